// File: rtl/inst_sram_if.sv
//------------------------------------------------------------------------------
// Module      : inst_sram_if
// Description : Instruction-SRAM request/response bundle between the fetch
//               stage (master) and the instruction memory (slave).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface inst_sram_if;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        init_done;
  logic        addr_err;

  // Fetch stage drives requests and observes responses
  modport master (
    output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    input  inst_sram_rdata, init_done, addr_err
  );

  // Memory consumes requests and produces responses
  modport slave (
    input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    output inst_sram_rdata, init_done, addr_err
  );
endinterface

`default_nettype wire

// File: rtl/inst_sram_resp.sv
//------------------------------------------------------------------------------
// Module      : inst_sram_resp
// Description : Instruction-SRAM responder. Fills every word with a NOP after
//               reset, then serves 1-cycle-latency reads (read-first) and
//               byte-masked writes at byte addresses relative to BASE_ADDR.
//               Optional macro INST_SRAM_STAT_EN adds saturating read/write
//               request counters (rd_count / wr_count).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module inst_sram_resp #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h1c000000,
  parameter logic [31:0] FILL_WORD = 32'h03400000
) (
  input  wire logic        clk,
  input  wire logic        resetn,
`ifdef INST_SRAM_STAT_EN
  output logic [31:0]      rd_count,
  output logic [31:0]      wr_count,
`endif
  inst_sram_if.slave       bus
);

  localparam int          c_DEPTH   = 1 << ADDR_W;
  localparam logic [32:0] c_SPAN    = 33'(1) << (ADDR_W + 2);
  localparam logic [0:0]  c_ST_INIT = 1'b0;
  localparam logic [0:0]  c_ST_RUN  = 1'b1;

  logic [31:0]       r_mem [c_DEPTH];
  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_init_done;
  logic [31:0]       r_rdata;
  logic              r_addr_err;

  logic [31:0]       w_off;
  logic              w_in_range;
  logic [ADDR_W-1:0] w_idx;
  logic              w_run_req;

  // Offset from the base uses 32-bit wrap, so addresses below BASE_ADDR land
  // far above the span and decode as out of range.
  assign w_off      = bus.inst_sram_addr - BASE_ADDR;
  assign w_in_range = ({1'b0, w_off} < c_SPAN);
  assign w_idx      = w_off[ADDR_W+1:2];
  assign w_run_req  = (r_state == c_ST_RUN) && bus.inst_sram_en;

  // INIT sequencer: one word per cycle, then RUN until the next reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= c_ST_INIT;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
    end else if (r_state == c_ST_INIT) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == {ADDR_W{1'b1}}) begin
        r_state     <= c_ST_RUN;
        r_init_done <= 1'b1;
      end
    end
  end

  // Memory array: NOP fill during INIT, byte-masked writes in RUN
  always_ff @(posedge clk) begin
    if (resetn) begin
      if (r_state == c_ST_INIT) begin
        r_mem[r_cnt] <= FILL_WORD;
      end else if (bus.inst_sram_en && w_in_range) begin
        for (int i = 0; i < 4; i++) begin
          if (bus.inst_sram_we[i]) begin
            r_mem[w_idx][8*i +: 8] <= bus.inst_sram_wdata[8*i +: 8];
          end
        end
      end
    end
  end

  // Read port and range error; the array read sees the pre-write word
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rdata    <= '0;
      r_addr_err <= 1'b0;
    end else if (w_run_req) begin
      if (w_in_range) begin
        r_rdata    <= r_mem[w_idx];
        r_addr_err <= 1'b0;
      end else begin
        r_rdata    <= '0;
        r_addr_err <= 1'b1;
      end
    end else begin
      r_addr_err <= 1'b0;
    end
  end

`ifdef INST_SRAM_STAT_EN
  logic [31:0] r_rd_count;
  logic [31:0] r_wr_count;

  // Saturating counters of served in-range reads and writes
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else if (w_run_req && w_in_range) begin
      if (bus.inst_sram_we == 4'h0) begin
        if (r_rd_count != 32'hFFFFFFFF) r_rd_count <= r_rd_count + 32'd1;
      end else begin
        if (r_wr_count != 32'hFFFFFFFF) r_wr_count <= r_wr_count + 32'd1;
      end
    end
  end

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;
`endif

  assign bus.inst_sram_rdata = r_rdata;
  assign bus.init_done       = r_init_done;
  assign bus.addr_err        = r_addr_err;

endmodule

`default_nettype wire

// File: tb/tb_inst_sram_resp.sv
//------------------------------------------------------------------------------
// Module      : tb_inst_sram_resp
// Description : Self-checking bench for inst_sram_resp with ADDR_W=4.
//               Also exercises the INST_SRAM_STAT_EN counters when defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_inst_sram_resp;

  localparam logic [31:0] BASE = 32'h1c000000;
  localparam logic [31:0] NOP  = 32'h03400000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  inst_sram_if bus ();

`ifdef INST_SRAM_STAT_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
  int          exp_rd = 0;
  int          exp_wr = 0;
`endif

  inst_sram_resp #(.ADDR_W(4)) dut (
    .clk      (clk),
    .resetn   (resetn),
`ifdef INST_SRAM_STAT_EN
    .rd_count (rd_count),
    .wr_count (wr_count),
`endif
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mkv(logic en, logic [3:0] we, logic [31:0] addr,
                               logic [31:0] wdata, logic [31:0] er, logic ee);
    vec_t v;
    v.en = en; v.we = we; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Advance one active edge and settle just after it
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [3:0] we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.inst_sram_en    = en;
    bus.inst_sram_we    = we;
    bus.inst_sram_addr  = addr;
    bus.inst_sram_wdata = wdata;
  endtask

  // Track expected stat counts for a request issued in RUN
  task automatic count_req(input logic en, input logic [3:0] we, input logic [31:0] addr);
`ifdef INST_SRAM_STAT_EN
    logic [31:0] off;
    off = addr - BASE;
    if (en && off < 32'd64) begin
      if (we == 4'h0) exp_rd++;
      else            exp_wr++;
    end
`else
    if (en && we == 4'hF && addr == 32'h0) checks = checks + 0;
`endif
  endtask

  initial begin
    vecs[0]  = mkv(1'b1, 4'hF, 32'h1c000008, 32'h11223344, NOP,          1'b0);
    vecs[1]  = mkv(1'b1, 4'h5, 32'h1c000008, 32'hAABBCCDD, 32'h11223344, 1'b0);
    vecs[2]  = mkv(1'b1, 4'h0, 32'h1c000008, 32'h0,        32'h11BB33DD, 1'b0);
    vecs[3]  = mkv(1'b1, 4'hF, 32'h1c00000c, 32'h12345678, NOP,          1'b0);
    vecs[4]  = mkv(1'b1, 4'hF, 32'h1c00000c, 32'h0,        32'h12345678, 1'b0);
    vecs[5]  = mkv(1'b1, 4'h0, 32'h1c00000c, 32'h0,        32'h0,        1'b0);
    vecs[6]  = mkv(1'b0, 4'h0, 32'h1c00000c, 32'h0,        32'h0,        1'b0);
    vecs[7]  = mkv(1'b1, 4'h0, 32'h1bfffffc, 32'h0,        32'h0,        1'b1);
    vecs[8]  = mkv(1'b1, 4'hF, 32'h1c000040, 32'hFFFFFFFF, 32'h0,        1'b1);
    vecs[9]  = mkv(1'b0, 4'h0, 32'h1c000040, 32'h0,        32'h0,        1'b0);
    vecs[10] = mkv(1'b1, 4'h0, 32'h1c000000, 32'h0,        NOP,          1'b0);
    vecs[11] = mkv(1'b0, 4'h0, 32'h1c000000, 32'h0,        NOP,          1'b0);
    vecs[12] = mkv(1'b1, 4'h0, 32'h1c00000b, 32'h0,        32'h11BB33DD, 1'b0);
    vecs[13] = mkv(1'b1, 4'h3, 32'h1c00003c, 32'h0000BEEF, NOP,          1'b0);
    vecs[14] = mkv(1'b1, 4'h0, 32'h1c00003c, 32'h0,        32'h0340BEEF, 1'b0);

    drive(1'b0, 4'h0, 32'h0, 32'h0);

    // Reset state
    resetn = 1'b0;
    cyc();
    chk("reset_rdata", bus.inst_sram_rdata, 32'h0);
    chk("reset_init_done", {31'h0, bus.init_done}, 32'h0);
    chk("reset_addr_err", {31'h0, bus.addr_err}, 32'h0);

    // INIT: 16 cycles, a write attempt on cycle 3 must be ignored
    resetn = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k == 2) drive(1'b1, 4'hF, 32'h1c000004, 32'hDEADBEEF);
      else        drive(1'b0, 4'h0, 32'h0, 32'h0);
      cyc();
      chk($sformatf("init_done_c%0d", k + 1), {31'h0, bus.init_done}, {31'h0, k == 15});
      chk($sformatf("init_rdata_c%0d", k + 1), bus.inst_sram_rdata, 32'h0);
      chk($sformatf("init_err_c%0d", k + 1), {31'h0, bus.addr_err}, 32'h0);
    end

    // Every word holds the NOP fill
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'h0, BASE + 32'(4 * i), 32'h0);
      count_req(1'b1, 4'h0, BASE + 32'(4 * i));
      cyc();
      chk($sformatf("fill_word%0d", i), bus.inst_sram_rdata, NOP);
    end

    // Directed vectors: writes, read-first, range errors, hold
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      count_req(vecs[i].en, vecs[i].we, vecs[i].addr);
      cyc();
      chk($sformatf("vec%0d_rdata", i), bus.inst_sram_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), {31'h0, bus.addr_err}, {31'h0, vecs[i].exp_err});
    end
    drive(1'b0, 4'h0, 32'h0, 32'h0);

`ifdef INST_SRAM_STAT_EN
    chk("rd_count", rd_count, 32'(exp_rd));
    chk("wr_count", wr_count, 32'(exp_wr));
`endif

    // Reset in RUN, then again at INIT cycle 8
    resetn = 1'b0;
    cyc();
    chk("rerun_rst_init_done", {31'h0, bus.init_done}, 32'h0);
    chk("rerun_rst_rdata", bus.inst_sram_rdata, 32'h0);
`ifdef INST_SRAM_STAT_EN
    chk("rst_rd_count", rd_count, 32'h0);
    chk("rst_wr_count", wr_count, 32'h0);
`endif
    resetn = 1'b1;
    for (int k = 0; k < 7; k++) cyc();
    chk("mid_init_done", {31'h0, bus.init_done}, 32'h0);
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    for (int k = 0; k < 16; k++) begin
      cyc();
      chk($sformatf("reinit_done_c%0d", k + 1), {31'h0, bus.init_done}, {31'h0, k == 15});
    end

    // Memory refilled by the second INIT
    drive(1'b1, 4'h0, 32'h1c00000c, 32'h0);
    cyc();
    chk("refill_word3", bus.inst_sram_rdata, NOP);
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
